// File: rtl/addsub_bist.sv
// Purpose: on-chip stimulus generator and response checker for a WIDTH-bit adder-subtractor.
// Latency: 2+SETTLE_CYCLES cycles per vector, NUM_VECTORS*(2+SETTLE_CYCLES) cycles per run.
// Backpressure: none; start is accepted only in IDLE/DONE and ignored while busy.
// Build option: define ADDSUB_BIST_STOP_ON_ERR_EN to end the run on the first mismatching vector.
module addsub_bist #(
  parameter int          WIDTH         = 4,        // 2..8
  parameter int          NUM_VECTORS   = 10,       // 1..255
  parameter int          SETTLE_CYCLES = 1,        // >= 1
  parameter logic [15:0] SEED          = 16'hACE1  // 0 is remapped to 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] A_o,
  output logic [WIDTH-1:0] B_o,
  output logic             Cin_o,
  input  logic [WIDTH-1:0] S_i,
  input  logic             Cout_i,
  input  logic             V_i,
  output logic [7:0]       vec_count,
  output logic [7:0]       err_count
);

  // An all-zero Galois LFSR never leaves zero, so a zero seed is remapped.
  localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam int          WCW       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(SETTLE_CYCLES - 1);
  localparam logic [7:0]  VEC_LAST  = 8'(NUM_VECTORS);

`ifdef ADDSUB_BIST_STOP_ON_ERR_EN
  localparam bit STOP_ON_ERR = 1'b1;
`else
  localparam bit STOP_ON_ERR = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_WAIT,
    ST_CHECK,
    ST_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [15:0]      lfsr, lfsr_nxt, lfsr_step;
  logic [WCW-1:0]   wait_cnt, wait_cnt_nxt;
  logic [WIDTH-1:0] a_nxt, b_nxt;
  logic             cin_nxt;
  logic             busy_nxt, done_nxt, pass_nxt;
  logic [7:0]       vec_nxt, err_nxt;

  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   gold;
  logic             ve;
  logic             mismatch;
  logic [7:0]       vec_inc;
  logic [7:0]       err_inc;
  logic             end_run;

  // Golden model of the unit under test, evaluated on the held operands.
  always_comb begin
    bx       = B_o ^ {WIDTH{Cin_o}};
    gold     = {1'b0, A_o} + {1'b0, bx} + {{WIDTH{1'b0}}, Cin_o};
    ve       = (A_o[WIDTH-1] == bx[WIDTH-1]) && (gold[WIDTH-1] != A_o[WIDTH-1]);
    mismatch = ({S_i, Cout_i, V_i} != {gold[WIDTH-1:0], gold[WIDTH], ve});
  end

  // One Galois right-shift step of the pattern generator.
  always_comb begin
    lfsr_step = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
  end

  // Counter updates for the vector being checked; the error count saturates.
  always_comb begin
    vec_inc = vec_count + 8'd1;
    err_inc = (mismatch && (err_count != 8'hFF)) ? (err_count + 8'd1) : err_count;
    end_run = (vec_inc == VEC_LAST) || (STOP_ON_ERR && mismatch);
  end

  // Next-state and next-output logic; everything holds unless a state says otherwise.
  always_comb begin
    state_nxt    = state;
    lfsr_nxt     = lfsr;
    wait_cnt_nxt = wait_cnt;
    a_nxt        = A_o;
    b_nxt        = B_o;
    cin_nxt      = Cin_o;
    busy_nxt     = busy;
    done_nxt     = done;
    pass_nxt     = pass;
    vec_nxt      = vec_count;
    err_nxt      = err_count;

    case (state)
      ST_IDLE, ST_DONE: begin
        // A new run always replays the same sequence from the seed.
        if (start) begin
          state_nxt = ST_DRIVE;
          lfsr_nxt  = SEED_EFF;
          a_nxt     = SEED_EFF[WIDTH-1:0];
          b_nxt     = SEED_EFF[2*WIDTH-1:WIDTH];
          cin_nxt   = 1'b0;
          busy_nxt  = 1'b1;
          done_nxt  = 1'b0;
          pass_nxt  = 1'b0;
          vec_nxt   = 8'd0;
          err_nxt   = 8'd0;
        end
      end

      ST_DRIVE: begin
        // Operands are already on the bus; start the settle timer.
        state_nxt    = ST_WAIT;
        wait_cnt_nxt = '0;
      end

      ST_WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          state_nxt = ST_CHECK;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end

      ST_CHECK: begin
        vec_nxt  = vec_inc;
        err_nxt  = err_inc;
        lfsr_nxt = lfsr_step;
        if (end_run) begin
          // Operands are left untouched so a failing vector stays visible.
          state_nxt = ST_DONE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          pass_nxt  = (err_inc == 8'd0);
        end else begin
          // Even vectors add, odd vectors subtract.
          state_nxt = ST_DRIVE;
          a_nxt     = lfsr_step[WIDTH-1:0];
          b_nxt     = lfsr_step[2*WIDTH-1:WIDTH];
          cin_nxt   = vec_inc[0];
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset forces IDLE with all outputs low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      lfsr      <= SEED_EFF;
      wait_cnt  <= '0;
      A_o       <= '0;
      B_o       <= '0;
      Cin_o     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      vec_count <= 8'd0;
      err_count <= 8'd0;
    end else begin
      state     <= state_nxt;
      lfsr      <= lfsr_nxt;
      wait_cnt  <= wait_cnt_nxt;
      A_o       <= a_nxt;
      B_o       <= b_nxt;
      Cin_o     <= cin_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      pass      <= pass_nxt;
      vec_count <= vec_nxt;
      err_count <= err_nxt;
    end
  end

endmodule

// File: tb/tb_addsub_bist.sv
// Purpose: self-checking bench for addsub_bist with a behavioural adder-subtractor and fault modes.
// Latency: expects 3 cycles per vector with the default settle time.
// Backpressure: none; start pulses are driven directly.
module tb_addsub_bist;

  localparam int W = 4;
`ifdef ADDSUB_BIST_STOP_ON_ERR_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         start2 = 1'b0;
  int           mode = 0;

  logic         busy, done, pass, cin, cout, v;
  logic [W-1:0] a, b, s;
  logic [7:0]   vec_count, err_count;

  logic         busy2, done2, pass2, cin2, cout2, v2;
  logic [W-1:0] a2, b2, s2;
  logic [7:0]   vec_count2, err_count2;

  logic [W+1:0] r1, r2;

  vec_t q[$];
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  addsub_bist dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .busy(busy), .done(done), .pass(pass),
    .A_o(a), .B_o(b), .Cin_o(cin),
    .S_i(s), .Cout_i(cout), .V_i(v),
    .vec_count(vec_count), .err_count(err_count)
  );

  addsub_bist #(.NUM_VECTORS(255)) dut255 (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .busy(busy2), .done(done2), .pass(pass2),
    .A_o(a2), .B_o(b2), .Cin_o(cin2),
    .S_i(s2), .Cout_i(cout2), .V_i(v2),
    .vec_count(vec_count2), .err_count(err_count2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference adder-subtractor from plain integer arithmetic: returns {S, Cout, V}.
  function automatic logic [W+1:0] ref_calc(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic c);
    int ux, uy, sx, sy, ur, sr;
    logic [W-1:0] sum;
    logic co, ov;
    ux = int'(x);
    uy = int'(y);
    sx = x[W-1] ? ux - (1 << W) : ux;
    sy = y[W-1] ? uy - (1 << W) : uy;
    if (c) begin
      ur = ux - uy;
      co = (ux >= uy);
      sr = sx - sy;
    end else begin
      ur = ux + uy;
      co = (ur >= (1 << W));
      sr = sx + sy;
    end
    sum = ur[W-1:0];
    ov  = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
    return {sum, co, ov};
  endfunction

  // 0: healthy, 1: V stuck at 0, 2: S inverted, 3: S stuck at 0.
  function automatic logic [W+1:0] apply_fault(input int md, input logic [W+1:0] r);
    logic [W+1:0] o;
    o = r;
    case (md)
      1: o[0] = 1'b0;
      2: o[W+1:2] = ~r[W+1:2];
      3: o[W+1:2] = '0;
      default: o = r;
    endcase
    return o;
  endfunction

  always_comb begin
    r1 = apply_fault(mode, ref_calc(a, b, cin));
    r2 = apply_fault(2, ref_calc(a2, b2, cin2));
  end
  assign {s, cout, v}    = r1;
  assign {s2, cout2, v2} = r2;

  // Build the expected operand sequence and the expected run outcome.
  task automatic plan(input int md, input int n, input bit push, output int nv, output int ne);
    logic [15:0]  l;
    logic [W+1:0] good, got;
    vec_t         e;
    if (push) q.delete();
    l  = 16'hACE1;
    nv = 0;
    ne = 0;
    for (int i = 0; i < n; i++) begin
      e.a = l[W-1:0];
      e.b = l[2*W-1:W];
      e.c = i[0];
      if (push) q.push_back(e);
      good = ref_calc(e.a, e.b, e.c);
      got  = apply_fault(md, good);
      nv   = i + 1;
      if (got != good && ne < 255) ne++;
      l = {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
      if (STOP && got != good) break;
    end
  endtask

  // Scoreboard: each newly driven vector of the small instance is popped and compared.
  logic       busy_q = 1'b0;
  logic [7:0] vc_q = 8'd0;
  always @(negedge clk) begin
    vec_t e;
    if (busy && (!busy_q || vec_count != vc_q)) begin
      if (q.size() == 0) begin
        chk("sb_empty", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("sb_a", 32'(a), 32'(e.a));
        chk("sb_b", 32'(b), 32'(e.b));
        chk("sb_cin", 32'(cin), 32'(e.c));
      end
    end
    busy_q <= busy;
    vc_q   <= vec_count;
  end

  task automatic run(input string tag, input bit big, input int md, input bit extra_start);
    int nv, ne, cyc;
    bit fin;
    if (!big) mode = md;
    plan(md, big ? 255 : 10, !big, nv, ne);
    @(posedge clk);
    #1;
    if (big) start2 = 1'b1; else start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    start2 = 1'b0;
    if (!big) begin
      chk({tag, "_a0"}, 32'(a), 32'h1);
      chk({tag, "_b0"}, 32'(b), 32'hE);
      chk({tag, "_c0"}, 32'(cin), 32'h0);
    end
    cyc = 0;
    fin = 1'b0;
    for (int k = 0; k < 2000 && !fin; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (big ? busy2 : busy) cyc++;
      if (extra_start && cyc == 5) start = 1'b1;
      fin = big ? done2 : done;
    end
    start = 1'b0;
    chk({tag, "_timeout"}, 32'(fin), 32'd1);
    chk({tag, "_busycyc"}, 32'(cyc), 32'(nv * 3));
    chk({tag, "_pass"}, 32'(big ? pass2 : pass), 32'(ne == 0));
    chk({tag, "_vec"}, 32'(big ? vec_count2 : vec_count), 32'(nv));
    chk({tag, "_err"}, 32'(big ? err_count2 : err_count), 32'(ne));
    if (!big) chk({tag, "_sbleft"}, 32'(q.size()), 32'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_pass"}, 32'(pass), 32'd0);
    chk({tag, "_a"}, 32'(a), 32'd0);
    chk({tag, "_b"}, 32'(b), 32'd0);
    chk({tag, "_cin"}, 32'(cin), 32'd0);
    chk({tag, "_vec"}, 32'(vec_count), 32'd0);
    chk({tag, "_err"}, 32'(err_count), 32'd0);
  endtask

  initial begin
    int nv, ne;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("rst");
    rst_n = 1'b1;

    run("good", 1'b0, 0, 1'b0);
    run("vfault", 1'b0, 1, 1'b0);
    run("restart_busy", 1'b0, 0, 1'b1);
    run("szero", 1'b0, 3, 1'b0);

    // Asynchronous reset in the middle of a run.
    mode = 0;
    plan(0, 10, 1'b1, nv, ne);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    run("rerun", 1'b0, 0, 1'b0);

    run("sat", 1'b1, 2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
